fetch_stage: RTL

IF stage plus IF/ID pipeline register for the 5-stage RISC-V pipeline, directly upstream of the main decoder.
- Holds the PC and drives the instruction-memory address; instruction memory is external with a combinational read.
- Selects the next PC (sequential or EX-stage redirect) and registers the fetched instruction, PC and PC+4 into the decode stage.
- Exposes op/funct3 slices of the decode-stage instruction for the decoder.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/pipe_reg_en_clr.sv | 23 ++
 rtl/fetch_stage.sv | 74 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: datapath width, reset/bubble values and the
// base opcode encodings used by both fetch and the main decoder.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with synchronous reset, synchronous clear and load enable.
// Reset and clear both load RST_VAL and take priority over the enable.
module pipe_reg_en_clr #(
    parameter int unsigned   W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC selection, imem addressing and the
// registered instruction/PC/PC+4/valid handed to decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [6:0]      opD,
    output logic [2:0]      funct3D
);

    localparam int unsigned IFID_W = 1 + 32 + 2 * XLEN;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};

    logic [XLEN-1:0]   PCPlus4F;
    logic [XLEN-1:0]   PCNextF;
    logic              pc_en;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;

    // Wraps silently at the top of the address space.
    assign PCPlus4F = PCF + XLEN'(4);

    // A redirect must land even while fetch is stalled, so it forces the enable.
    assign PCNextF = PCSrcE ? PCTargetE : PCPlus4F;
    assign pc_en   = PCSrcE || !StallF;

    pipe_reg_en_clr #(
        .W       (XLEN),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (pc_en),
        .d     (PCNextF),
        .q     (PCF)
    );

    assign ifid_d = {1'b1, InstrF, PCF, PCPlus4F};

    pipe_reg_en_clr #(
        .W       (IFID_W),
        .RST_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (FlushD),
        .en    (!StallD),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign {ValidD, InstrD, PCD, PCPlus4D} = ifid_q;

    assign opD     = InstrD[6:0];
    assign funct3D = InstrD[14:12];

endmodule
